// File: rtl/clas_bist_if.sv
// Bus between clas_bist and the add/subtract unit it exercises.
// slave: the BIST block itself. master: whatever sits on the other side
// (system control plus the unit under test).
interface clas_bist_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dut_result;
  logic             dut_c_out;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_sel;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_sel;
  logic [WIDTH-1:0] fail_result;

  modport slave (
    input  start, dut_result, dut_c_out,
    output dut_a, dut_b, dut_sel, busy, done, pass,
           fail_a, fail_b, fail_sel, fail_result
  );

  modport master (
    output start, dut_result, dut_c_out,
    input  dut_a, dut_b, dut_sel, busy, done, pass,
           fail_a, fail_b, fail_sel, fail_result
  );
endinterface

// File: rtl/clas_bist.sv
// Exhaustive BIST driver/checker for the carry look-ahead add/subtract unit.
// Sweeps sel (outer), a (middle), b (inner), holds each vector SETTLE cycles,
// compares the unit's outputs with a built-in model and stops on the first
// mismatch, latching the failing operands and the observed result.
module clas_bist #(
  parameter int WIDTH      = 16,
  parameter int SETTLE     = 1,
  parameter int CHECK_COUT = 1
) (
  input logic       clk,
  input logic       rst_n,
  clas_bist_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // {sel, a, b} packed so the whole sweep is a single binary count.
  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           r_state, w_state_nxt;
  logic [VW-1:0]    r_vec, w_vec_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [WIDTH-1:0] r_fail_a, w_fail_a_nxt;
  logic [WIDTH-1:0] r_fail_b, w_fail_b_nxt;
  logic             r_fail_sel, w_fail_sel_nxt;
  logic [WIDTH-1:0] r_fail_result, w_fail_result_nxt;

  logic [WIDTH-1:0] w_a, w_b;
  logic             w_sel;
  logic [WIDTH:0]   w_sum;
  logic             w_mismatch;
  logic             w_last;
  logic             w_cmp_edge;

  assign w_a   = r_vec[2*WIDTH-1:WIDTH];
  assign w_b   = r_vec[WIDTH-1:0];
  assign w_sel = r_vec[2*WIDTH];

  // Reference: a + b, or a + ~b + 1 for subtract; top bit is carry / no-borrow.
  assign w_sum = {1'b0, w_a} + {1'b0, (w_sel ? ~w_b : w_b)} + (WIDTH+1)'(w_sel);

  assign w_mismatch = (bus.dut_result != w_sum[WIDTH-1:0]) ||
                      ((CHECK_COUT != 0) && (bus.dut_c_out != w_sum[WIDTH]));
  assign w_last     = &r_vec;
  assign w_cmp_edge = (r_cnt == CW'(SETTLE - 1));

  // State and datapath registers; everything clears on reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vec         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_a      <= '0;
      r_fail_b      <= '0;
      r_fail_sel    <= 1'b0;
      r_fail_result <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vec         <= w_vec_nxt;
      r_cnt         <= w_cnt_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_pass        <= w_pass_nxt;
      r_fail_a      <= w_fail_a_nxt;
      r_fail_b      <= w_fail_b_nxt;
      r_fail_sel    <= w_fail_sel_nxt;
      r_fail_result <= w_fail_result_nxt;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a hold default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt       = r_state;
    w_vec_nxt         = r_vec;
    w_cnt_nxt         = r_cnt;
    w_busy_nxt        = r_busy;
    w_done_nxt        = r_done;
    w_pass_nxt        = r_pass;
    w_fail_a_nxt      = r_fail_a;
    w_fail_b_nxt      = r_fail_b;
    w_fail_sel_nxt    = r_fail_sel;
    w_fail_result_nxt = r_fail_result;

    case (r_state)
      S_IDLE, S_DONE: begin
        // A new run wipes the previous verdict on the same edge.
        if (bus.start) begin
          w_state_nxt       = S_RUN;
          w_vec_nxt         = '0;
          w_cnt_nxt         = '0;
          w_busy_nxt        = 1'b1;
          w_done_nxt        = 1'b0;
          w_pass_nxt        = 1'b0;
          w_fail_a_nxt      = '0;
          w_fail_b_nxt      = '0;
          w_fail_sel_nxt    = 1'b0;
          w_fail_result_nxt = '0;
        end
      end
      S_RUN: begin
        if (!w_cmp_edge) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_mismatch) begin
          // Vector stays on the bus so the failing case can be probed.
          w_state_nxt       = S_DONE;
          w_busy_nxt        = 1'b0;
          w_done_nxt        = 1'b1;
          w_pass_nxt        = 1'b0;
          w_fail_a_nxt      = w_a;
          w_fail_b_nxt      = w_b;
          w_fail_sel_nxt    = w_sel;
          w_fail_result_nxt = bus.dut_result;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = 1'b1;
        end else begin
          w_vec_nxt = r_vec + 1'b1;
          w_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.dut_a       = w_a;
  assign bus.dut_b       = w_b;
  assign bus.dut_sel     = w_sel;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail_a      = r_fail_a;
  assign bus.fail_b      = r_fail_b;
  assign bus.fail_sel    = r_fail_sel;
  assign bus.fail_result = r_fail_result;

endmodule
